// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - 8-phase instruction-cycle sequencer with sticky halt
// Phase/halted registers plus opcode decode into PC, IR, ACC and memory controls.
module cpu_sequencer #(
   parameter logic HALT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       resume,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic       data_e,
   output logic       halt
);

   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   logic [2:0] phase_q, phase_d;
   logic       halted_q, halted_d;
   logic       alu_op;
   logic       halt_op;
   logic       resume_go;

   assign alu_op    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
   assign halt_op   = (opcode == OP_HLT) && HALT_EN;
   assign resume_go = halted_q && resume && ena;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Halt freezes the phase at OP_ADDR; resume skips straight to OP_FETCH.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (ena) begin
         if (halted_q) begin
            if (resume) begin
               phase_d  = PH_OP_FETCH;
               halted_d = 1'b0;
            end
         end else if ((phase_q == PH_OP_ADDR) && halt_op) begin
            halted_d = 1'b1;
         end else begin
            phase_d = phase_q + 3'd1;
         end
      end
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      inc_pc = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      if (halted_q) begin
         inc_pc = resume_go;
         halt   = !resume_go;
      end else begin
         case (phase_q)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = !halt_op;
               halt   = halt_op;
            end
            PH_OP_FETCH: begin
               rd = alu_op;
            end
            PH_ALU_OP: begin
               rd     = alu_op;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
               rd     = alu_op;
               ld_ac  = alu_op;
               ld_pc  = (opcode == OP_JMP);
               wr     = (opcode == OP_STO);
               data_e = (opcode == OP_STO);
            end
            default: begin
               sel = 1'b0;
            end
         endcase
      end
   end

   assign phase = phase_q;

endmodule
